// File: rtl/sevenseg_scan_ctl_if.sv
// rtl/sevenseg_scan_ctl_if.sv - display word inputs and segment/anode outputs of the scan controller
interface sevenseg_scan_ctl_if #(
  parameter int NDIG = 8
);
  logic [7*NDIG-1:0] d;
  logic [3:0]        bright;
  logic [NDIG-1:0]   blink_en;
  logic              lz_en;
  logic [6:0]        segs_n;
  logic              dp_n;
  logic [NDIG-1:0]   an_n;
  logic              frame_start;

  modport master (
    output d, bright, blink_en, lz_en,
    input  segs_n, dp_n, an_n, frame_start
  );

  modport slave (
    input  d, bright, blink_en, lz_en,
    output segs_n, dp_n, an_n, frame_start
  );
endinterface

// File: rtl/sevenseg_scan_ctl.sv
// rtl/sevenseg_scan_ctl.sv - multiplexed seven-segment scanner with PWM, blink, zero suppression and frame snapshots
module sevenseg_scan_ctl #(
  parameter int NDIG         = 8,
  parameter int DIG_CYCLES   = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input logic                clk,
  input logic                rst_n,
  sevenseg_scan_ctl_if.slave bus
);

  localparam int SUBN = DIG_CYCLES / 16;
  localparam int SW   = (SUBN > 1) ? $clog2(SUBN) : 1;
  localparam int DW   = $clog2(NDIG);
  localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SW-1:0]     sub;
  logic [3:0]        phase;
  logic [DW-1:0]     digit;
  logic [FW-1:0]     frame;
  logic              blink_off;

  logic [7*NDIG-1:0] sh_d;
  logic [NDIG-1:0]   sh_blink;
  logic              sh_lz;
  logic              sh_boff;

  logic              valid_q;
  logic              start_q;
  logic [DW-1:0]     digit_q;
  logic [3:0]        phase_q;

  logic              at_start;
  logic [6:0]        word;
  logic [NDIG-1:0]   suppress;
  logic              run;
  logic              eff_blank;

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    case (v)
      4'h0: hex_font = 7'b1000000;
      4'h1: hex_font = 7'b1111001;
      4'h2: hex_font = 7'b0100100;
      4'h3: hex_font = 7'b0110000;
      4'h4: hex_font = 7'b0011001;
      4'h5: hex_font = 7'b0010010;
      4'h6: hex_font = 7'b0000010;
      4'h7: hex_font = 7'b1111000;
      4'h8: hex_font = 7'b0000000;
      4'h9: hex_font = 7'b0010000;
      4'hA: hex_font = 7'b0001000;
      4'hB: hex_font = 7'b0000011;
      4'hC: hex_font = 7'b1000110;
      4'hD: hex_font = 7'b0100001;
      4'hE: hex_font = 7'b0000110;
      default: hex_font = 7'b0001110;
    endcase
  endfunction

  assign at_start = (sub == '0) && (phase == 4'd0) && (digit == '0);

  // Counters, frame snapshot, and a one-deep copy of the scan position so
  // the outputs line up with the snapshot that was just taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub       <= '0;
      phase     <= '0;
      digit     <= '0;
      frame     <= '0;
      blink_off <= 1'b0;
      sh_d      <= '0;
      sh_blink  <= '0;
      sh_lz     <= 1'b0;
      sh_boff   <= 1'b0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      digit_q   <= '0;
      phase_q   <= '0;
    end else begin
      if (sub == SW'(SUBN - 1)) begin
        sub   <= '0;
        phase <= phase + 4'd1;
        if (phase == 4'd15) begin
          if (digit == DW'(NDIG - 1)) begin
            digit <= '0;
            if (frame == FW'(BLINK_FRAMES - 1)) begin
              frame     <= '0;
              blink_off <= ~blink_off;
            end else begin
              frame <= frame + FW'(1);
            end
          end else begin
            digit <= digit + DW'(1);
          end
        end
      end else begin
        sub <= sub + SW'(1);
      end

      if (at_start) begin
        sh_d     <= bus.d;
        sh_blink <= bus.blink_en;
        sh_lz    <= bus.lz_en;
        sh_boff  <= blink_off;
      end

      valid_q <= 1'b1;
      start_q <= at_start;
      digit_q <= digit;
      phase_q <= phase;
    end
  end

  // Suppression runs down from the top digit and stops at the first non-zero word.
  always_comb begin
    word     = sh_d[7*int'(digit_q) +: 7];
    run      = 1'b1;
    suppress = '0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      run         = run & (sh_d[7*k +: 7] == 7'd0);
      suppress[k] = run & sh_lz;
    end
    eff_blank = word[6] | (sh_blink[digit_q] & sh_boff) | suppress[digit_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.segs_n      <= 7'h7F;
      bus.dp_n        <= 1'b1;
      bus.an_n        <= '1;
      bus.frame_start <= 1'b0;
    end else if (!valid_q) begin
      bus.segs_n      <= 7'h7F;
      bus.dp_n        <= 1'b1;
      bus.an_n        <= '1;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= start_q;
      if (eff_blank) begin
        bus.segs_n <= 7'h7F;
        bus.dp_n   <= 1'b1;
        bus.an_n   <= '1;
      end else begin
        bus.segs_n <= word[4] ? 7'b0111111 : hex_font(word[3:0]);
        bus.dp_n   <= ~word[5];
        bus.an_n   <= (phase_q <= bus.bright) ? ~(NDIG'(1) << digit_q) : '1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// tb/tb_sevenseg_scan_ctl.sv - randomized scoreboard bench for sevenseg_scan_ctl against a frame-level reference model
module tb_sevenseg_scan_ctl;

  localparam int NDIG  = 4;
  localparam int DC    = 32;
  localparam int BF    = 2;
  localparam int FRAME = NDIG * DC;
  localparam int PH    = DC / 16;

  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [6:0]      segs;
    logic            dp;
    logic [NDIG-1:0] an;
    logic            fs;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   ecount;
  exp_t q[$];

  logic [6:0]      snap_w [NDIG];
  logic [NDIG-1:0] snap_blink;
  logic            snap_lz;

  sevenseg_scan_ctl_if #(.NDIG(NDIG)) bus_if ();

  sevenseg_scan_ctl #(
    .NDIG(NDIG), .DIG_CYCLES(DC), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: position in the scan is derived from the edge count since reset release.
  always @(posedge clk) begin
    exp_t e;
    int   n, f, w, dig, ph;
    logic boff, sup, blank;
    logic [6:0] wd;
    if (!rst_n) begin
      ecount = 0;
    end else begin
      ecount++;
      if (ecount == 1) begin
        e = '{segs: 7'h7F, dp: 1'b1, an: '1, fs: 1'b0};
      end else begin
        n    = ecount - 2;
        f    = n / FRAME;
        w    = n % FRAME;
        dig  = w / DC;
        ph   = (w % DC) / PH;
        boff = ((f / BF) % 2) == 1;
        wd   = snap_w[dig];
        sup  = snap_lz && (dig >= 1);
        for (int j = dig; j < NDIG; j++) if (snap_w[j] != 7'd0) sup = 1'b0;
        blank = wd[6] || (snap_blink[dig] && boff) || sup;
        e.fs  = (w == 0);
        if (blank) begin
          e.segs = 7'h7F;
          e.dp   = 1'b1;
          e.an   = '1;
        end else begin
          e.segs = wd[4] ? 7'b0111111 : FONT[wd[3:0]];
          e.dp   = ~wd[5];
          e.an   = (ph <= int'(bus_if.bright)) ? ~(NDIG'(1) << dig) : '1;
        end
      end
      q.push_back(e);
      if ((ecount - 1) % FRAME == 0) begin
        for (int j = 0; j < NDIG; j++) snap_w[j] = bus_if.d[7*j +: 7];
        snap_blink = bus_if.blink_en;
        snap_lz    = bus_if.lz_en;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk("segs_n", 32'(bus_if.segs_n), 32'(e.segs));
      chk("dp_n", 32'(bus_if.dp_n), 32'(e.dp));
      chk("an_n", 32'(bus_if.an_n), 32'(e.an));
      chk("frame_start", 32'(bus_if.frame_start), 32'(e.fs));
    end
  end

  task automatic set_words(input logic [6:0] w3, input logic [6:0] w2,
                           input logic [6:0] w1, input logic [6:0] w0);
    bus_if.d = {w3, w2, w1, w0};
  endtask

  task automatic frames(input int k);
    repeat (k * FRAME) @(negedge clk);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_segs_n"}, 32'(bus_if.segs_n), 32'h7F);
    chk({tag, "_dp_n"}, 32'(bus_if.dp_n), 32'h1);
    chk({tag, "_an_n"}, 32'(bus_if.an_n), 32'hF);
    chk({tag, "_frame_start"}, 32'(bus_if.frame_start), 32'h0);
  endtask

  function automatic logic [6:0] rand_word();
    if ($urandom_range(0, 1) == 0) return 7'h00;
    return 7'($urandom);
  endfunction

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    ecount = 0;
    rst_n  = 1'b0;
    set_words(7'h03, 7'h02, 7'h01, 7'h00);
    bus_if.bright   = 4'd15;
    bus_if.blink_en = '0;
    bus_if.lz_en    = 1'b0;
    repeat (3) @(negedge clk);
    chk_dark("reset");
    rst_n = 1'b1;
    frames(2);

    bus_if.bright = 4'd3;
    frames(1);
    bus_if.bright = 4'd0;
    frames(1);
    bus_if.bright = 4'd15;

    set_words(7'h03, 7'h02, 7'h7F, 7'h00);
    frames(1);
    set_words(7'h03, 7'h02, 7'h18, 7'h00);
    frames(1);
    set_words(7'h03, 7'h02, 7'h25, 7'h00);
    frames(1);

    set_words(7'h00, 7'h00, 7'h10, 7'h00);
    bus_if.lz_en = 1'b1;
    frames(2);
    bus_if.lz_en = 1'b0;
    frames(2);

    bus_if.blink_en = 4'b0001;
    set_words(7'h04, 7'h03, 7'h02, 7'h01);
    frames(5);
    repeat (50) @(negedge clk);
    set_words(7'h0A, 7'h0B, 7'h0C, 7'h0D);
    frames(2);

    rst_n = 1'b0;
    @(negedge clk);
    q.delete();
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_dark("midreset");
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    frames(2);

    for (int i = 0; i < 40; i++) begin
      set_words(rand_word(), rand_word(), rand_word(), rand_word());
      bus_if.bright   = 4'($urandom);
      bus_if.blink_en = 4'($urandom);
      bus_if.lz_en    = 1'($urandom);
      repeat ($urandom_range(20, 200)) @(negedge clk);
    end

    #1 chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctl.md
# sevenseg_scan_ctl

Parametrised successor to the eight-digit seven-segment controller. It time-multiplexes NDIG common-anode digits and adds four features: PWM brightness control, per-digit blinking, leading-zero suppression, and frame-coherent input snapshots. It sits between the datapath's per-digit display words and the board's segment and anode pins.

## Interface
- NDIG, 8: number of digits scanned (2..16).
- DIG_CYCLES, 100000: clk cycles per digit slot. Must be a multiple of 16 and ≥ 32.
- BLINK_FRAMES, 64: full scan frames per blink half-period (≥ 1).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- d  in  7*NDIG  packed digit words. Digit i is d[7*i+6 : 7*i].
  - Bit 6: blank.
  - Bit 5: dp.
  - Bit 4: dash.
  - Bits 3:0: hex value.
- bright  in  4  brightness level; duty = (bright+1)/16 of each slot.
- blink_en  in  NDIG  per-digit blink enable.
- lz_en  in  1  leading-zero suppression enable.
- segs_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  NDIG  anodes, active-low, one-hot-or-none.
- frame_start  out  1  one-cycle pulse at the start of digit 0's slot.

## Operation
- Counters:
  - sub: 0..DIG_CYCLES/16-1.
  - phase: 0..15, advances when sub wraps.
  - digit: 0..NDIG-1, advances when phase wraps from 15; wraps from NDIG-1 to 0.
  - frame: 0..BLINK_FRAMES-1, advances when digit wraps.
  - blink_off: toggles when frame wraps.
- Snapshot: when digit=0, phase=0, sub=0 (the frame-start state), d, blink_en and lz_en are latched into shadow registers. bright is not snapshotted; it is sampled live every cycle. The whole frame displays only shadow values, so no mid-frame tearing occurs.
- Effective blank for digit k is set by any of:
  - shadow blank bit.
  - blink_en[k] & blink_off.
  - Leading-zero suppression. With lz_en set, digit k (k ≥ 1) is suppressed if it and every higher digit has blank=0, dash=0, dp=0, value=0. Digit 0 is never suppressed. Explicitly blanked higher digits are not "zero" and end suppression.
- Segment priority: effective blank → all segments and dp off; else dash → g only (segs_n=7'b0111111); else standard hex font (0→1000000, 1→1111001, 8→0000000, F→0001110). dp_n = ~dp when not blanked.
- Anode: an_n[digit] is low only when phase ≤ bright and the digit is not effectively blank. Otherwise all anodes are high.
- Guard: phase 15 with bright=15 still drives the anode. Digits never overlap because anode and segments update in the same register stage.

## Timing
- Reset (asynchronous assert, synchronous-effect deassert):
  - All counters, shadows and blink_off are cleared.
  - segs_n=7'h7F, dp_n=1, an_n=all ones, frame_start=0.
- All outputs are registered and reflect the counter and shadow state of the previous cycle, so latency is 1 cycle.
  - The first clk edge after rst_n rises: snapshot loads and the counters are at the frame-start state.
  - Second edge: frame_start=1 and outputs show digit 0, using the snapshot just loaded.
- frame_start asserts once every NDIG*DIG_CYCLES cycles, one cycle wide.
- Blink period is 2*BLINK_FRAMES frames. The first half after reset is on (blink_off=0).
- bright changes take effect at the next cycle's duty compare; no glitch rule beyond that.
- Reset mid-frame: outputs go dark immediately (asynchronous). Scanning restarts at digit 0 with a fresh snapshot.
- d changes mid-frame are invisible until the next frame_start.

## Test plan
Bench parameters: NDIG=4, DIG_CYCLES=32 (2 cycles per phase, 128-cycle frame), BLINK_FRAMES=2.

- Reset/scan: d={7'h03,7'h02,7'h01,7'h00}, bright=15. Release reset → frame_start every 128 cycles. an_n walks 1110, 1101, 1011, 0111, each for 32 cycles. segs_n: 1000000, 1111001, 0100100, 0110000.
- Brightness: bright=3 → each anode low for exactly 8 of its 32 cycles (phases 0..3). bright=0 → 2 cycles.
- Priority: digit 1 word = 7'h7F (blank) → dark for its slot. 7'h18 → dash only. 7'h25 → segs_n=0010010, dp_n=0.
- Leading zero: d={00,00,10(dash),00}, lz_en=1 → digits 3 and 2 dark, digit 1 dash, digit 0 shows "0". Repeat with lz_en=0 → all four lit.
- Blink and snapshot: blink_en=4'b0001 → digit 0 on for frames 0–1, off for frames 2–3, repeating. Change d at cycle 50 → displayed value changes only after the next frame_start.
- Mid-frame reset: assert rst_n=0 during digit 2 → an_n=1111 in the same cycle. After release, digit 0 is shown first.
